// File: rtl/fitness_pkg.sv
// Shared state encoding and width/field helpers for the fitness stimulus-and-scoring engine.
package fitness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Field helpers operate on a zero-extended copy so one function serves any vector width.
    localparam int FIELD_MAX_W = 64;

    function automatic int vecWidth(input int inW, input int outW);
        return inW + outW;
    endfunction

    function automatic int scoreWidth(input int testCount, input int outW);
        return $clog2(testCount * outW + 1);
    endfunction

    function automatic int idxWidth(input int testCount);
        return (testCount > 1) ? $clog2(testCount) : 1;
    endfunction

    function automatic int counterWidth(input int maxCount);
        return (maxCount > 1) ? $clog2(maxCount) : 1;
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] inputsField(input logic [FIELD_MAX_W-1:0] vec,
                                                           input int outW);
        return vec >> outW;
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] expectedField(input logic [FIELD_MAX_W-1:0] vec,
                                                             input int outW);
        return vec & ((FIELD_MAX_W'(1) << outW) - FIELD_MAX_W'(1));
    endfunction

endpackage

// File: rtl/match_counter.sv
// Counts how many candidate output bits agree with the expected bits (popcount of XNOR).
module match_counter #(
    parameter  int OUT_W = 2,
    localparam int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic [OUT_W-1:0] actual_i,
    input  logic [OUT_W-1:0] expected_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            count_o = count_o + CNT_W'(actual_i[i] ~^ expected_i[i]);
        end
    end

endmodule

// File: rtl/fitness_stimulus_scorer.sv
// Applies a loadable test-vector table to a candidate circuit and scores matching output bits.
// Optional per-vector failure logging (fail_map, first_fail) is enabled by FITNESS_FAIL_LOG_EN.
module fitness_stimulus_scorer
    import fitness_pkg::*;
#(
    parameter  int IN_W       = 3,
    parameter  int OUT_W      = 2,
    parameter  int TEST_COUNT = 8,
    parameter  int SETTLE     = 1,
    localparam int VEC_W      = vecWidth(IN_W, OUT_W),
    localparam int IDX_W      = idxWidth(TEST_COUNT),
    localparam int SCORE_W    = scoreWidth(TEST_COUNT, OUT_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    input  logic               vec_we,
    input  logic [IDX_W-1:0]   vec_addr,
    input  logic [VEC_W-1:0]   vec_wdata,
    output logic [IN_W-1:0]    dut_in,
    input  logic [OUT_W-1:0]   dut_out
`ifdef FITNESS_FAIL_LOG_EN
    ,
    output logic [TEST_COUNT-1:0] fail_map,
    output logic [IDX_W:0]        first_fail
`endif
);

    localparam int CNT_W    = $clog2(OUT_W + 1);
    localparam int SETTLE_W = counterWidth(SETTLE);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(TEST_COUNT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [VEC_W-1:0]    table_q [TEST_COUNT];
    state_e              state_d, state_q;
    logic [IDX_W-1:0]    idx_d, idx_q;
    logic [SETTLE_W-1:0] settleCnt_d, settleCnt_q;
    logic [SCORE_W-1:0]  score_d, score_q;
    logic [IN_W-1:0]     dutIn_d, dutIn_q;
    logic [VEC_W-1:0]    curVec;
    logic [IN_W-1:0]     curInputs;
    logic [OUT_W-1:0]    curExpected;
    logic [CNT_W-1:0]    matchCount;
    logic                tableWrite;

    assign curVec      = table_q[idx_q];
    assign curInputs   = IN_W'(inputsField(FIELD_MAX_W'(curVec), OUT_W));
    assign curExpected = OUT_W'(expectedField(FIELD_MAX_W'(curVec), OUT_W));

    match_counter #(
        .OUT_W(OUT_W)
    ) u_match_counter (
        .actual_i  (dut_out),
        .expected_i(curExpected),
        .count_o   (matchCount)
    );

    // The table is only writable while no pass is reading it; it is deliberately not reset.
    assign tableWrite = vec_we && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                        && (int'(vec_addr) < TEST_COUNT);

    always_ff @(posedge clk) begin
        if (tableWrite) begin
            table_q[vec_addr] <= vec_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            settleCnt_q <= '0;
            score_q     <= '0;
            dutIn_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settleCnt_q <= settleCnt_d;
            score_q     <= score_d;
            dutIn_q     <= dutIn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settleCnt_d = settleCnt_q;
        score_d     = score_q;
        dutIn_d     = dutIn_q;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    score_d     = '0;
                    idx_d       = '0;
                    settleCnt_d = '0;
                    state_d     = ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy    = 1'b1;
                dutIn_d = curInputs;
                state_d = (SETTLE > 0) ? ST_SETTLE : ST_COMPARE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settleCnt_q == SETTLE_LAST) begin
                    settleCnt_d = '0;
                    state_d     = ST_COMPARE;
                end else begin
                    settleCnt_d = settleCnt_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                busy    = 1'b1;
                score_d = score_q + SCORE_W'(matchCount);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign score  = score_q;
    assign dut_in = dutIn_q;

`ifdef FITNESS_FAIL_LOG_EN
    logic [TEST_COUNT-1:0] failMap_d, failMap_q;
    logic [IDX_W-1:0]      firstIdx_d, firstIdx_q;
    logic                  firstValid_d, firstValid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failMap_q    <= '0;
            firstIdx_q   <= '0;
            firstValid_q <= 1'b0;
        end else begin
            failMap_q    <= failMap_d;
            firstIdx_q   <= firstIdx_d;
            firstValid_q <= firstValid_d;
        end
    end

    // Vectors are compared in ascending order, so the first recorded failure is the lowest index.
    always_comb begin
        failMap_d    = failMap_q;
        firstIdx_d   = firstIdx_q;
        firstValid_d = firstValid_q;
        if ((state_q == ST_IDLE) && start) begin
            failMap_d    = '0;
            firstIdx_d   = '0;
            firstValid_d = 1'b0;
        end else if ((state_q == ST_COMPARE) && (dut_out != curExpected)) begin
            failMap_d[idx_q] = 1'b1;
            if (!firstValid_q) begin
                firstValid_d = 1'b1;
                firstIdx_d   = idx_q;
            end
        end
    end

    assign fail_map   = failMap_q;
    assign first_fail = {firstValid_q, firstIdx_q};
`endif

endmodule

// File: tb/tb_fitness_stimulus_scorer.sv
// Self-checking bench: three scorers (SETTLE 1, 0, 3) share one table and stimulus stream.
module tb_fitness_stimulus_scorer;

    localparam int TC        = 8;
    localparam int MAX_EDGES = 45;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vecWe;
    logic [2:0] vecAddr;
    logic [4:0] vecWdata;

    logic [2:0] busyV;
    logic [2:0] doneV;
    logic [4:0] scoreV  [3];
    logic [2:0] dutInV  [3];
    logic [1:0] dutOutV [3];
`ifdef FITNESS_FAIL_LOG_EN
    logic [7:0] failMapV   [3];
    logic [3:0] firstFailV [3];
`endif

    logic [1:0] candLut [8];
    logic [4:0] tbl     [8];
    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    function automatic int settleOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        assign dutOutV[g] = candLut[dutInV[g]];
        fitness_stimulus_scorer #(
            .IN_W(3), .OUT_W(2), .TEST_COUNT(TC), .SETTLE(settleOf(g))
        ) dut (
            .clk(clk), .rst(rst), .start(start),
            .busy(busyV[g]), .done(doneV[g]), .score(scoreV[g]),
            .vec_we(vecWe), .vec_addr(vecAddr), .vec_wdata(vecWdata),
            .dut_in(dutInV[g]), .dut_out(dutOutV[g])
`ifdef FITNESS_FAIL_LOG_EN
            , .fail_map(failMapV[g]), .first_fail(firstFailV[g])
`endif
        );
    end

    typedef struct packed {
        int         mode;
        int         expScore;
        logic [7:0] expMap;
        logic [3:0] expFirst;
    } dirVec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [4:0] data);
        vecWe    = 1'b1;
        vecAddr  = addr;
        vecWdata = data;
        @(posedge clk);
        #1;
        vecWe    = 1'b0;
        tbl[addr] = data;
    endtask

    // mode 0: working full adder, 1: carry stuck at 0, 2: both outputs inverted
    task automatic setCandidate(input int mode);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] x;
            logic s, c;
            x = 3'(i);
            s = ^x;
            c = (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
            case (mode)
                1:       candLut[i] = {s, 1'b0};
                2:       candLut[i] = {~s, ~c};
                default: candLut[i] = {s, c};
            endcase
        end
    endtask

    function automatic int modelScore();
        int s = 0;
        for (int k = 0; k < TC; k++)
            for (int b = 0; b < 2; b++)
                if (candLut[tbl[k][4:2]][b] == tbl[k][b]) s++;
        return s;
    endfunction

    function automatic logic [7:0] modelMap();
        logic [7:0] m = '0;
        for (int k = 0; k < TC; k++)
            if (candLut[tbl[k][4:2]] != tbl[k][1:0]) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] modelFirst(input logic [7:0] m);
        for (int k = 0; k < TC; k++)
            if (m[k]) return {1'b1, 3'(k)};
        return 4'b0000;
    endfunction

    task automatic runPass(input string tag, input int expScore, input logic [7:0] expMap,
                           input logic [3:0] expFirst, input bit disturb, input bit withWrite,
                           input logic [2:0] wAddr, input logic [4:0] wData);
        int doneEdge [3];
        int doneCnt  [3];
        bit busyOk, seqOk;
        for (int i = 0; i < 3; i++) begin
            doneEdge[i] = -1;
            doneCnt[i]  = 0;
        end
        busyOk = 1'b1;
        seqOk  = 1'b1;
        start  = 1'b1;
        if (withWrite) begin
            vecWe    = 1'b1;
            vecAddr  = wAddr;
            vecWdata = wData;
            tbl[wAddr] = wData;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        vecWe = 1'b0;
        if (busyV[0] !== 1'b1) busyOk = 1'b0;
        for (int e = 1; e <= MAX_EDGES; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (doneV[i] === 1'b1) begin
                    doneCnt[i]++;
                    if (doneEdge[i] < 0) doneEdge[i] = e;
                end
            end
            if (e < TC * 3 && busyV[0] !== 1'b1) busyOk = 1'b0;
            if (e == TC * 3 && busyV[0] !== 1'b0) busyOk = 1'b0;
            if ((e % 3 == 2) && (e / 3 < TC) && (dutInV[0] !== tbl[e / 3][4:2])) seqOk = 1'b0;
            if (disturb) begin
                start    = (e == 4);
                vecWe    = (e == 5);
                vecAddr  = 3'd2;
                vecWdata = 5'b010_01;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s done cycle s%0d", tag, settleOf(i)), doneEdge[i] + 1,
                        TC * (settleOf(i) + 2) + 1);
            checkOutput($sformatf("%s score s%0d", tag, settleOf(i)), 32'(scoreV[i]), expScore);
        end
        checkOutput({tag, " done pulses"}, doneCnt[0], 1);
        checkOutput({tag, " busy window"}, 32'(busyOk), 1);
        checkOutput({tag, " dut_in sequence"}, 32'(seqOk), 1);
`ifdef FITNESS_FAIL_LOG_EN
        checkOutput({tag, " fail_map"}, 32'(failMapV[0]), 32'(expMap));
        checkOutput({tag, " first_fail"}, 32'(firstFailV[0]), 32'(expFirst));
`endif
    endtask

    task automatic heldStartSequence();
        int  d1 = -1;
        int  d2 = -1;
        bit  restartOk = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            if (doneV[0] === 1'b1) begin
                if (d1 < 0) d1 = e;
                else if (d2 < 0) d2 = e;
            end
            if (e == 25 && busyV[0] !== 1'b0) restartOk = 1'b0;
            if (e == 26 && busyV[0] !== 1'b1) restartOk = 1'b0;
            if (e == 30) start = 1'b0;
        end
        checkOutput("held start first done cycle", d1 + 1, 25);
        checkOutput("held start restart", 32'(restartOk), 1);
        checkOutput("held start second done cycle", d2 + 1, 51);
        checkOutput("held start score", 32'(scoreV[0]), 16);
    endtask

    task automatic abortSequence();
        bit quietOk = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busyV[0]), 0);
        checkOutput("abort done", 32'(doneV[0]), 0);
        checkOutput("abort score", 32'(scoreV[0]), 0);
        checkOutput("abort dut_in", 32'(dutInV[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (doneV !== 3'b000 || busyV !== 3'b000) quietOk = 1'b0;
        end
        checkOutput("abort no done or restart", 32'(quietOk), 1);
    endtask

    initial begin
        dirVec_t dirVecs [3];
        logic [7:0] m;
        dirVecs[0] = '{mode: 0, expScore: 16, expMap: 8'b0000_0000, expFirst: 4'b0000};
        dirVecs[1] = '{mode: 1, expScore: 12, expMap: 8'b1110_1000, expFirst: 4'b1011};
        dirVecs[2] = '{mode: 2, expScore: 0,  expMap: 8'b1111_1111, expFirst: 4'b1000};

        rst      = 1'b1;
        start    = 1'b0;
        vecWe    = 1'b0;
        vecAddr  = '0;
        vecWdata = '0;
        setCandidate(0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busyV[0]), 0);
        checkOutput("reset done", 32'(doneV[0]), 0);
        checkOutput("reset score", 32'(scoreV[0]), 0);
        checkOutput("reset dut_in", 32'(dutInV[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < TC; i++) begin
            logic [2:0] x;
            x = 3'(i);
            applyStimulus(x, {x, ^x, (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0])});
        end

        for (int t = 0; t < 3; t++) begin
            setCandidate(dirVecs[t].mode);
            runPass($sformatf("dir%0d", t), dirVecs[t].expScore, dirVecs[t].expMap,
                    dirVecs[t].expFirst, 1'b0, 1'b0, 3'd0, 5'd0);
        end

        setCandidate(0);
        runPass("busy ignore", 16, 8'h00, 4'b0000, 1'b1, 1'b0, 3'd0, 5'd0);
        abortSequence();
        runPass("after abort", 16, 8'h00, 4'b0000, 1'b0, 1'b0, 3'd0, 5'd0);
        runPass("write with start", 14, 8'b1000_0000, 4'b1111, 1'b0, 1'b1, 3'd7, 5'b111_00);
        applyStimulus(3'd7, 5'b111_11);
        heldStartSequence();

        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < TC; k++) applyStimulus(3'(k), 5'($urandom));
            for (int i = 0; i < 8; i++) candLut[i] = 2'($urandom);
            m = modelMap();
            runPass($sformatf("rand%0d", r), modelScore(), m, modelFirst(m), 1'b0, 1'b0, 3'd0, 5'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fitness_stimulus_scorer.md
Name: fitness_stimulus_scorer

Overview:
Synthesizable stimulus-and-scoring engine: the driving end of the candidate-circuit evaluation interface.
- Holds a loadable test-vector table and applies each vector's input bits to a candidate circuit.
- Waits a programmable settle time, compares the candidate's outputs against the expected bits, and accumulates a per-bit fitness score.
- Sits beside each evolved individual so fitness is computed in hardware rather than by a simulation bench.

Parameters:
IN_W, 3, candidate input width (a, b, ci for a full adder)
OUT_W, 2, candidate output width (sum, co)
TEST_COUNT, 8, number of vectors in the table
SETTLE, 1, idle cycles between applying inputs and sampling outputs (0 legal)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin evaluation pass; honoured only in IDLE
busy  out  1  high from first APPLY through last COMPARE
done  out  1  one-cycle pulse when score is final
score  out  $clog2(TEST_COUNT*OUT_W+1)  matching output bits, held until next start
vec_we  in  1  table write strobe
vec_addr  in  $clog2(TEST_COUNT)  table write index
vec_wdata  in  IN_W+OUT_W  {inputs MSB-first, expected outputs MSB-first}
dut_in  out  IN_W  registered stimulus to candidate
dut_out  in  OUT_W  candidate response, sampled in COMPARE

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; busy=0, done=0, score=0, dut_in=0.
  - Vector index and settle counter = 0.
  - Table contents are not reset.
- FSM states and transitions:
  - IDLE: start=1 -> clear score and index, go to APPLY.
  - APPLY (1 cycle): dut_in <= table[idx][IN_W+OUT_W-1:OUT_W]. Go to SETTLE if SETTLE>0, else COMPARE.
  - SETTLE (SETTLE cycles): counter counts to SETTLE-1, then COMPARE.
  - COMPARE (1 cycle): score += popcount(~(dut_out ^ table[idx][OUT_W-1:0])).
    - idx==TEST_COUNT-1 -> DONE.
    - Otherwise idx++ and go to APPLY.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - Start sampled at edge 0 gives done high in cycle TEST_COUNT*(SETTLE+2)+1. Default: cycle 25.
  - busy=1 in every APPLY, SETTLE and COMPARE cycle.
  - dut_in holds its last vector after DONE.
- Width rules:
  - Score saturation is impossible by sizing; maximum score = TEST_COUNT*OUT_W (16 default).
  - popcount result is zero-extended to score width.
- Boundary conditions:
  - start while not IDLE: ignored; no restart.
  - start held high: a new pass begins the cycle after DONE (IDLE sees start).
  - vec_we while busy: write dropped. In IDLE or DONE: write takes effect next cycle.
  - vec_addr >= TEST_COUNT: write dropped.
  - vec_we and start in the same IDLE cycle: the write lands first; APPLY of vector 0 reads the new data.
  - rst mid-pass: immediate abort to reset values; no done pulse.

Optional Feature:
Macro: FITNESS_FAIL_LOG_EN.
- Defined: adds two outputs.
  - fail_map (TEST_COUNT bits): bit i set if vector i had any mismatching output bit.
  - first_fail (index width + 1 valid bit): index of the lowest failing vector.
  - Both are cleared on start and on rst, and are final with done.
- Undefined: ports and logic are absent; score behaviour is identical.

Decomposition:
- Package fitness_pkg:
  - state enum {IDLE, APPLY, SETTLE, COMPARE, DONE}.
  - Localparam functions for vector width and score width.
  - Field-slice helper for inputs/expected bits.
- One sub-module: match_counter.
  - Combinational popcount of XNOR, parameterized by OUT_W.
  - Reused by future multi-output candidates.

Test Plan:
- Load the 8 full-adder vectors (000_00, 001_10, 010_10, 011_01, 100_10, 101_01, 110_01, 111_11) with a correct adder attached, start at edge 0 -> done in cycle 25, score=16, dut_in sequence 000..111.
- Same vectors, candidate with co tied to 0 -> score=12. With FITNESS_FAIL_LOG_EN: fail_map=8'b1110_1000, first_fail=3.
- Candidate outputs inverted (~sum, ~co) -> score=0; all fail_map bits set.
- SETTLE=0 -> done in cycle 17. SETTLE=3 -> done in cycle 41; score unchanged for the correct adder.
- start pulsed in cycle 5, vec_we to addr 2 in cycle 6 -> both ignored, score=16. Then rst in cycle 10 of a second pass -> busy=0, score=0, no done, dut_in=000.
- vec_we with addr 7 (vector 111_00) together with start in IDLE -> new data used; correct adder scores 14.
